// File: rtl/kv260_blink_monitor_pkg.sv
// Shared types and window/threshold helpers for the blink monitor.
package kv260_blink_monitor_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MEASURE = 2'd1,
      LOCKED  = 2'd2
   } state_t;

   localparam int unsigned EDGE_COUNT_W = 16;

   // Lower window bound clamps to 1 when the tolerance swallows the whole period.
   function automatic int unsigned win_lo(input int unsigned count_limit, input int unsigned tolerance);
      return (tolerance >= count_limit) ? 32'd1 : count_limit - tolerance;
   endfunction

   function automatic int unsigned win_hi(input int unsigned count_limit, input int unsigned tolerance);
      return count_limit + tolerance;
   endfunction

   function automatic int unsigned timeout_thr(input int unsigned count_limit, input int unsigned tolerance);
      return count_limit + tolerance + 1;
   endfunction

endpackage

// File: rtl/kv260_blink_monitor_if.sv
// Blink-monitor signal bundle: the slave side is the monitor, the master side drives it.
interface kv260_blink_monitor_if #(
   parameter int unsigned COUNTER_WIDTH = 32
);
   logic                     clear;
   logic                     in_sig;
   logic [COUNTER_WIDTH-1:0] half_period;
   logic                     half_valid;
   logic                     locked;
   logic                     error;
   logic                     timeout;
   logic [15:0]              edge_count;
   logic [COUNTER_WIDTH-1:0] min_half;
   logic [COUNTER_WIDTH-1:0] max_half;

   modport master (
      output clear, in_sig,
      input  half_period, half_valid, locked, error, timeout, edge_count, min_half, max_half
   );

   modport slave (
      input  clear, in_sig,
      output half_period, half_valid, locked, error, timeout, edge_count, min_half, max_half
   );
endinterface

// File: rtl/kv260_blink_monitor_sync.sv
// Multi-flop synchroniser for the asynchronous blink input plus a registered level-change pulse.
module kv260_blink_monitor_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic async_i,
   output logic edge_o
);
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   edge_q;

   // The edge pulse is registered, so it lands one cycle after the last sync stage.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= '0;
         prev_q <= 1'b0;
         edge_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
         prev_q <= sync_q[SYNC_STAGES-1];
         edge_q <= sync_q[SYNC_STAGES-1] ^ prev_q;
      end
   end

   assign edge_o = edge_q;
endmodule

// File: rtl/kv260_blink_monitor.sv
// Blink half-period checker with lock/error/timeout status.
// Optional min/max statistics enabled by defining KV260_BLINK_MONITOR_STATS_EN.
module kv260_blink_monitor
   import kv260_blink_monitor_pkg::*;
#(
   parameter int unsigned COUNT_LIMIT   = 100000000,
   parameter int unsigned TOLERANCE     = 16,
   parameter int unsigned LOCK_COUNT    = 4,
   parameter int unsigned SYNC_STAGES   = 2,
   parameter int unsigned COUNTER_WIDTH = 32
) (
   input logic                 clk,
   input logic                 reset,
   kv260_blink_monitor_if.slave mon
);
   localparam logic [COUNTER_WIDTH-1:0] WIN_LO = COUNTER_WIDTH'(win_lo(COUNT_LIMIT, TOLERANCE));
   localparam logic [COUNTER_WIDTH-1:0] WIN_HI = COUNTER_WIDTH'(win_hi(COUNT_LIMIT, TOLERANCE));
   localparam logic [COUNTER_WIDTH-1:0] THR    = COUNTER_WIDTH'(timeout_thr(COUNT_LIMIT, TOLERANCE));
   localparam int unsigned GW = $clog2(LOCK_COUNT + 1);

   state_t                   state_q;
   logic [COUNTER_WIDTH-1:0] cnt_q;
   logic [COUNTER_WIDTH-1:0] half_q;
   logic [GW-1:0]            good_q;
   logic                     hv_q;
   logic                     locked_q;
   logic                     err_q;
   logic                     to_q;
   logic [15:0]              ecnt_q;

   logic                     sig_edge;
   logic [COUNTER_WIDTH-1:0] meas_d;
   logic                     in_win;

   kv260_blink_monitor_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk    (clk),
      .reset  (reset),
      .async_i(mon.in_sig),
      .edge_o (sig_edge)
   );

   // The edge cycle itself is part of the half-period, hence the +1.
   assign meas_d = cnt_q + COUNTER_WIDTH'(1);
   assign in_win = (meas_d >= WIN_LO) && (meas_d <= WIN_HI);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         half_q   <= '0;
         good_q   <= '0;
         hv_q     <= 1'b0;
         locked_q <= 1'b0;
         err_q    <= 1'b0;
         to_q     <= 1'b0;
         ecnt_q   <= '0;
      end else begin
         hv_q <= 1'b0;
         if (mon.clear) begin
            err_q <= 1'b0;
            to_q  <= 1'b0;
         end
         case (state_q)
            IDLE: begin
               cnt_q <= '0;
               if (sig_edge) state_q <= MEASURE;
            end
            MEASURE, LOCKED: begin
               if (sig_edge) begin
                  cnt_q  <= '0;
                  half_q <= meas_d;
                  hv_q   <= 1'b1;
                  ecnt_q <= ecnt_q + 16'd1;
                  if (in_win) begin
                     if (state_q == MEASURE) begin
                        if (good_q == GW'(LOCK_COUNT - 1)) begin
                           good_q   <= GW'(LOCK_COUNT);
                           state_q  <= LOCKED;
                           locked_q <= 1'b1;
                        end else begin
                           good_q <= good_q + GW'(1);
                        end
                     end
                  end else begin
                     err_q    <= 1'b1;
                     good_q   <= '0;
                     state_q  <= MEASURE;
                     locked_q <= 1'b0;
                  end
               // An edge on the threshold cycle was handled above, so the edge wins.
               end else if (meas_d >= THR) begin
                  to_q     <= 1'b1;
                  good_q   <= '0;
                  cnt_q    <= '0;
                  state_q  <= IDLE;
                  locked_q <= 1'b0;
               end else begin
                  cnt_q <= meas_d;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign mon.half_period = half_q;
   assign mon.half_valid  = hv_q;
   assign mon.locked      = locked_q;
   assign mon.error       = err_q;
   assign mon.timeout     = to_q;
   assign mon.edge_count  = ecnt_q;

`ifdef KV260_BLINK_MONITOR_STATS_EN
   logic [COUNTER_WIDTH-1:0] min_q;
   logic [COUNTER_WIDTH-1:0] max_q;
   logic                     report;

   assign report = sig_edge && (state_q != IDLE);

   // A measurement coinciding with clear seeds the fresh statistics.
   always_ff @(posedge clk) begin
      if (reset) begin
         min_q <= '1;
         max_q <= '0;
      end else if (mon.clear) begin
         min_q <= report ? meas_d : '1;
         max_q <= report ? meas_d : '0;
      end else if (report) begin
         if (meas_d < min_q) min_q <= meas_d;
         if (meas_d > max_q) max_q <= meas_d;
      end
   end

   assign mon.min_half = min_q;
   assign mon.max_half = max_q;
`else
   assign mon.min_half = '0;
   assign mon.max_half = '0;
`endif
endmodule

// File: tb/tb_kv260_blink_monitor.sv
// Directed plus randomized bench for kv260_blink_monitor against a half-period level model.
module tb_kv260_blink_monitor;
   localparam int CL  = 100;
   localparam int TOL = 2;
   localparam int LC  = 4;
   localparam int SS  = 2;
   localparam int LAT = SS + 2;        // in_sig toggle to half_valid
   localparam int TO_TICK = LAT + CL + TOL + 1;

   logic clk = 1'b0;
   logic reset = 1'b1;

   kv260_blink_monitor_if #(.COUNTER_WIDTH(32)) bus ();

   kv260_blink_monitor #(
      .COUNT_LIMIT(CL), .TOLERANCE(TOL), .LOCK_COUNT(LC),
      .SYNC_STAGES(SS), .COUNTER_WIDTH(32)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .mon  (bus)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;

   // Reference model: abstract view in terms of toggles and gaps between them.
   bit          armed;
   int          good;
   bit          m_locked, m_err, m_to;
   logic [31:0] m_half, m_min, m_max;
   logic [15:0] m_ec;
   int          last_gap;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      armed = 0; good = 0; m_locked = 0; m_err = 0; m_to = 0;
      m_half = 0; m_ec = 0; m_min = 32'hFFFF_FFFF; m_max = 0;
   endtask

   task automatic model_clear();
      m_err = 0; m_to = 0; m_min = 32'hFFFF_FFFF; m_max = 0;
   endtask

   task automatic model_report(input int m);
      m_ec   = m_ec + 16'd1;
      m_half = m;
      if (m < m_min) m_min = m;
      if (m > m_max) m_max = m;
      if (m >= CL - TOL && m <= CL + TOL) begin
         good++;
         if (good >= LC) m_locked = 1;
      end else begin
         m_err = 1; good = 0; m_locked = 0;
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, "_hp"}, bus.half_period, m_half);
      chk({tag, "_lock"}, bus.locked, m_locked);
      chk({tag, "_err"}, bus.error, m_err);
      chk({tag, "_to"}, bus.timeout, m_to);
      chk({tag, "_ec"}, bus.edge_count, m_ec);
`ifdef KV260_BLINK_MONITOR_STATS_EN
      chk({tag, "_min"}, bus.min_half, m_min);
      chk({tag, "_max"}, bus.max_half, m_max);
`else
      chk({tag, "_min"}, bus.min_half, 0);
      chk({tag, "_max"}, bus.max_half, 0);
`endif
   endtask

   task automatic do_reset();
      reset = 1'b1; bus.in_sig = 1'b0; bus.clear = 1'b0;
      repeat (3) tick();
      reset = 1'b0;
      tick();
      model_reset();
      chk("rst_hv", bus.half_valid, 0);
      check_all("rst");
   endtask

   // Toggle in_sig, then hold it for n cycles; clear pulses on cycle clr_tick (0 = none).
   // n must be <= CL+TOL+1 or >= CL+TOL+6 so a timeout never straddles the next toggle.
   task automatic half(input int n, input int clr_tick);
      bit rep;
      rep = 0;
      bus.in_sig = ~bus.in_sig;
      if (!armed) armed = 1;
      else rep = 1;
      for (int k = 1; k <= n; k++) begin
         if (k == clr_tick) bus.clear = 1'b1;
         tick();
         bus.clear = 1'b0;
         if (k == clr_tick) model_clear();
         if (k == LAT - 1 || k == LAT + 1) chk("hv_idle", bus.half_valid, 0);
         if (k == LAT) begin
            if (rep) model_report(last_gap);
            chk("hv", bus.half_valid, rep);
            check_all("half");
         end
         if (armed && n > TO_TICK) begin
            if (k == TO_TICK - 1) chk("to_early", bus.timeout, m_to);
            if (k == TO_TICK) begin
               m_to = 1; good = 0; m_locked = 0; armed = 0;
               chk("to_fire", bus.timeout, 1);
               chk("to_unlock", bus.locked, 0);
            end
         end
      end
      last_gap = n;
   endtask

   initial begin
      int n, c;
      bus.in_sig = 1'b0;
      bus.clear  = 1'b0;
      last_gap   = 0;
      model_reset();
      do_reset();

      // Ideal toggling: five reports, lock on the fourth measurement.
      repeat (6) half(100, 0);
      chk("t1_ec", bus.edge_count, 5);
      chk("t1_lock", bus.locked, 1);
      chk("t1_err", bus.error, 0);

      // One long half drops lock; four good halves relock, error stays until clear.
      half(103, 0);
      half(100, 0);
      chk("t2_err", bus.error, 1);
      chk("t2_lock", bus.locked, 0);
      chk("t2_hp", bus.half_period, 103);
      repeat (4) half(100, 0);
      chk("t2_relock", bus.locked, 1);
      chk("t2_sticky", bus.error, 1);
      half(100, 10);
      chk("t2_clr", bus.error, 0);

      // Static input: timeout, then the next edge only re-arms.
      half(300, 0);
      chk("t3_to", bus.timeout, 1);
      half(100, 0);
      half(100, 0);

      // Window boundaries.
      half(98, 20);
      half(102, 0);
      half(97, 0);
      chk("t4_in", bus.error, 0);
      half(103, 0);
      chk("t4_lo", bus.error, 1);
      half(100, 4);
      chk("t4_setwins", bus.error, 1);

      // Reset in the middle of a half-period.
      half(50, 0);
      do_reset();
      repeat (5) half(100, 0);
      chk("t5_lock", bus.locked, 1);
      chk("t5_ec", bus.edge_count, 4);

      // Statistics.
      half(99, 15);
      half(101, 0);
      half(100, 0);
      half(100, 0);
`ifdef KV260_BLINK_MONITOR_STATS_EN
      chk("t6_min", bus.min_half, 99);
      chk("t6_max", bus.max_half, 101);
`else
      chk("t6_min", bus.min_half, 0);
      chk("t6_max", bus.max_half, 0);
`endif
      half(100, 10);

      // Randomized half-periods, occasional clears and timeouts.
      for (int i = 0; i < 50; i++) begin
         n = ($urandom_range(0, 9) == 0) ? $urandom_range(CL + TOL + 6, 140)
                                         : $urandom_range(CL - TOL - 4, CL + TOL + 1);
         c = ($urandom_range(0, 6) == 0) ? $urandom_range(1, 20) : 0;
         half(n, c);
      end
      half(100, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
